bts_mem_pattern_master: RTL and testbench

BTS_MEM_PATTERN_MASTER -- requirements
Module: bts_mem_pattern_master

---
 rtl/bts_mem_pattern_master.sv | 219 +++++++++++++++++++++
 tb/tb_bts_mem_pattern_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bts_mem_pattern_master.sv
// Memory pattern tester: Avalon-MM master that writes a pattern
// over a word range, reads it back and counts mismatches.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   start, abort        launch pulse (IDLE only), cancel level
//   base_addr, length   first word address, word count
//   seed, mode          pattern seed, 0=incrementing 1=LFSR
//   address..clken      Avalon-MM master command signals
//   readdata            read data, valid one cycle after command
//   busy, done, pass    status (done is a 1-cycle pulse)
//   err_count           saturating mismatch count
//   first_err_addr      address of the first mismatch
//
// Build option: define BTS_MEMTEST_INVERT_PASS_EN to add a second
// write/read pass (states WRI/RDI) using the inverted pattern.
// Timing: start seen in cycle 0, done in cycle 2*length+2
// (4*length+2 with the inverted pass); length 0 gives done in
// cycle 1.
module bts_mem_pattern_master #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   seed,
  input  logic                mode,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [DATA_W-1:0] TAPS =
    DATA_W'(32'h8020_0003);
  localparam logic [ADDR_W:0] ONE_L = (ADDR_W+1)'(1);

`ifdef BTS_MEMTEST_INVERT_PASS_EN
  typedef enum logic [2:0] {
    IDLE, WR, RD, WRI, RDI, DRAIN, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WR, RD, DRAIN, DONE
  } state_t;
`endif

  state_t state_q, state_d;

  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;
  logic              mode_q;
  logic [DATA_W-1:0] pat_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] rd_exp_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [15:0]       err_q;
  logic [ADDR_W-1:0] ferr_q;
  logic              pass_q;

  logic              last;
  logic              wr_ph;
  logic              rd_ph;
  logic              inv_ph;
  logic              cmd;
  logic              launch;
  logic              mism;
  logic [DATA_W-1:0] pat_nx;
  logic [DATA_W-1:0] seed_fix;
  logic [DATA_W-1:0] pat_out;

  function automatic logic [DATA_W-1:0] lfsr_step(
    input logic [DATA_W-1:0] x
  );
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  always_comb begin
    wr_ph  = 1'b0;
    rd_ph  = 1'b0;
    inv_ph = 1'b0;
    unique case (state_q)
      WR:      wr_ph = 1'b1;
      RD:      rd_ph = 1'b1;
`ifdef BTS_MEMTEST_INVERT_PASS_EN
      WRI: begin
        wr_ph  = 1'b1;
        inv_ph = 1'b1;
      end
      RDI: begin
        rd_ph  = 1'b1;
        inv_ph = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign last   = (idx_q == len_q - ONE_L);
  assign cmd    = (wr_ph | rd_ph) & ~abort;
  assign launch = (state_q == IDLE) & start & ~abort;
  assign pat_nx = mode_q ? lfsr_step(pat_q)
                         : pat_q + DATA_W'(1);
  assign seed_fix = (mode && seed == '0) ? DATA_W'(1)
                                         : seed;
  assign pat_out  = inv_ph ? ~pat_q : pat_q;

  // An abort cycle neither issues nor scores anything.
  assign mism = rd_pend_q & ~abort &
                (readdata != rd_exp_q);

  assign chipselect = cmd;
  assign write      = wr_ph & ~abort;
  assign byteenable = {BE_W{wr_ph & ~abort}};
  assign address    = base_q + idx_q[ADDR_W-1:0];
  assign writedata  = pat_out;
  assign clken      = 1'b1;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE) & ~abort;
  assign pass = done ? (err_q == '0) : pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (launch)
          state_d = (length == '0) ? DONE : WR;
      WR:
        if (last) state_d = RD;
`ifdef BTS_MEMTEST_INVERT_PASS_EN
      RD:
        if (last) state_d = WRI;
      WRI:
        if (last) state_d = RDI;
      RDI:
        if (last) state_d = DRAIN;
`else
      RD:
        if (last) state_d = DRAIN;
`endif
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      mode_q    <= 1'b0;
      pat_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_exp_q  <= '0;
      rd_addr_q <= '0;
      err_q     <= '0;
      ferr_q    <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_ph & ~abort;
      rd_exp_q  <= pat_out;
      rd_addr_q <= address;
      if (mism) begin
        if (err_q != 16'hFFFF)
          err_q <= err_q + 16'd1;
        if (err_q == '0)
          ferr_q <= rd_addr_q;
      end
      if (launch) begin
        base_q <= base_addr;
        len_q  <= length;
        mode_q <= mode;
        seed_q <= seed_fix;
        pat_q  <= seed_fix;
        idx_q  <= '0;
        err_q  <= '0;
        ferr_q <= '0;
        pass_q <= 1'b0;
      end
      // Each phase restarts the pattern from the seed.
      if (cmd) begin
        if (last) begin
          idx_q <= '0;
          pat_q <= seed_q;
        end else begin
          idx_q <= idx_q + ONE_L;
          pat_q <= pat_nx;
        end
      end
      if (done)
        pass_q <= (err_q == '0);
    end
  end

endmodule

// File: tb/tb_bts_mem_pattern_master.sv
// Self-checking bench for bts_mem_pattern_master: memory model,
// behavioural command-sequence model, random and directed tests.
module tb_bts_mem_pattern_master;

  localparam int AW = 17;
  localparam int DW = 32;

`ifdef BTS_MEMTEST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [DW-1:0] seed;
  logic          mode;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic [DW-1:0] writedata;
  logic          clken;
  logic [DW-1:0] readdata;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  always #5 clk = ~clk;

  bts_mem_pattern_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .abort(abort), .base_addr(base_addr),
    .length(length), .seed(seed), .mode(mode),
    .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write),
    .writedata(writedata), .clken(clken),
    .readdata(readdata), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  logic [DW-1:0] mem [logic [AW-1:0]];
  bit            stuck_en;
  logic [AW-1:0] stuck_addr;
  logic [DW-1:0] stuck_mask;

  always @(posedge clk) begin
    if (chipselect) begin
      if (write) begin
        mem[address] = writedata;
      end else begin
        readdata <= (mem.exists(address) ? mem[address] : '0)
                  | ((stuck_en && address == stuck_addr)
                     ? stuck_mask : '0);
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] nxt(input bit m,
                                      input logic [31:0] x);
    logic [31:0] r;
    if (!m) return x + 32'd1;
    r = x >> 1;
    if (x[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  typedef struct {
    bit            cs;
    bit            we;
    bit            dn;
    bit            mm;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } rec_t;

  task automatic run_test(input logic [AW-1:0] base,
                          input logic [AW:0]   len,
                          input logic [DW-1:0] sd,
                          input bit            md,
                          input int            abort_at,
                          input int            ghost_at,
                          output int           done_k);
    rec_t          q[$];
    rec_t          r;
    logic [DW-1:0] s, w, v, rv;
    logic [AW-1:0] a;
    int            e_err, e_ab;
    logic [AW-1:0] e_ferr;
    bit            aborted;
    q.delete();
    e_err  = 0;
    e_ferr = '0;
    s = (md && sd == 0) ? 32'd1 : sd;
    for (int p = 0; p < NPASS; p++) begin
      w = s;
      for (int i = 0; i < int'(len); i++) begin
        a = base + AW'(i);
        r = '{1, 1, 0, 0, a, (p == 1) ? ~w : w};
        q.push_back(r);
        w = nxt(md, w);
      end
      w = s;
      for (int i = 0; i < int'(len); i++) begin
        a  = base + AW'(i);
        v  = (p == 1) ? ~w : w;
        rv = v | ((stuck_en && a == stuck_addr)
                  ? stuck_mask : '0);
        r  = '{1, 0, 0, rv != v, a, v};
        if (rv != v) begin
          if (e_err == 0) e_ferr = a;
          if (e_err < 16'hFFFF) e_err++;
        end
        q.push_back(r);
        w = nxt(md, w);
      end
    end
    if (len != 0) q.push_back('{0, 0, 0, 0, '0, '0});
    q.push_back('{0, 0, 1, 0, '0, '0});
    // The compare of the record in cycle k lands in cycle k+1.
    e_ab = 0;
    for (int k = 1; k <= q.size() && k + 1 < abort_at; k++)
      if (q[k-1].mm) e_ab++;

    done_k = -1;
    @(posedge clk); #1;
    base_addr = base; length = len; seed = sd;
    mode = md; start = 1; abort = 0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_cs", chipselect, 0);
    aborted = 0;
    for (int k = 1; k <= q.size(); k++) begin
      @(posedge clk); #1;
      start = (k == ghost_at);
      abort = (k == abort_at);
      base_addr = AW'($urandom);
      seed      = $urandom;
      length    = (AW+1)'($urandom);
      mode      = 1'($urandom);
      #1;
      r = q[k-1];
      if (abort) begin
        chk("abort_cs", chipselect, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 1);
        aborted = 1;
        break;
      end
      chk("busy", busy, 1);
      chk("cs", chipselect, r.cs);
      chk("done", done, r.dn);
      if (done) done_k = k;
      if (r.cs) begin
        chk("we", write, r.we);
        chk("addr", address, r.a);
        if (r.we) begin
          chk("wdata", writedata, r.d);
          chk("be", byteenable, 4'hF);
        end
      end
      if (r.dn) begin
        chk("pass_at_done", pass, e_err == 0);
        chk("err_at_done", err_count, e_err);
      end
    end
    @(posedge clk); #1;
    start = 0; abort = 0;
    #1;
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("end_cs", chipselect, 0);
    if (aborted) begin
      chk("abort_pass", pass, 0);
      chk("abort_err", err_count, e_ab);
    end else begin
      chk("end_pass", pass, e_err == 0);
      chk("end_err", err_count, e_err);
      chk("end_ferr", first_err_addr, e_ferr);
    end
  endtask

  int dk;

  initial begin
    reset_n = 0; start = 0; abort = 0;
    base_addr = '0; length = '0; seed = '0; mode = 0;
    stuck_en = 0; stuck_addr = '0; stuck_mask = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cs", chipselect, 0);
    chk("rst_we", write, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ferr", first_err_addr, 0);
    chk("rst_clken", clken, 1);
    reset_n = 1;

    chk("pin_inc", nxt(0, 32'h100), 32'h101);
    chk("pin_lfsr1", nxt(1, 32'h1), 32'h8020_0003);
    chk("pin_lfsr2", nxt(1, 32'h8020_0003), 32'hC030_0002);

    run_test(0, 4, 32'h100, 0, -1, -1, dk);
    chk("t033_done_cycle", dk, 2 * NPASS * 4 + 2);
    chk("t033_mem2", mem[2], (NPASS == 2) ? ~32'h102 : 32'h102);

    stuck_en = 1; stuck_addr = 2; stuck_mask = 32'h1;
    run_test(0, 4, 32'h100, 0, -1, -1, dk);
    chk("t034_err", err_count, 1);
    chk("t034_ferr", first_err_addr, 2);
    chk("t034_pass", pass, 0);
    stuck_en = 0;

    run_test(17'h1FFFE, 4, 32'hABCD0000, 0, -1, -1, dk);
    chk("t035_pass", pass, 1);

    run_test(5, 0, 32'h55, 0, -1, -1, dk);
    chk("t036_done_cycle", dk, 1);

    run_test(0, 8, 32'h9, 1, 8 + 1 + 2, -1, dk);
    chk("t037_no_done", dk, -1);
    run_test(3, 3, 32'h7, 0, -1, 2, dk);
    chk("t037_restart", dk, 2 * NPASS * 3 + 2);

    run_test(0, 5, 32'h0, 1, -1, -1, dk);
    chk("t038_done_cycle", dk, 2 * NPASS * 5 + 2);
    chk("t038_pass", pass, 1);

    // start and abort together in IDLE: nothing starts
    @(posedge clk); #1;
    length = 4; start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    #1;
    chk("startabort_busy", busy, 0);
    chk("startabort_cs", chipselect, 0);

    for (int t = 0; t < 25; t++) begin
      logic [AW-1:0] b;
      logic [AW:0]   l;
      int            ab, gh;
      b = (t % 3 == 0) ? AW'(17'h1FFF0 + $urandom_range(15))
                       : AW'($urandom);
      l = (AW+1)'($urandom_range(0, 20));
      stuck_en   = ($urandom_range(1) == 1) && l != 0;
      stuck_addr = b + AW'($urandom_range(0, 19));
      stuck_mask = 32'h1 << $urandom_range(31);
      ab = ($urandom_range(4) == 0)
           ? $urandom_range(1, 2 * NPASS * int'(l) + 2) : -1;
      gh = (l > 1) ? $urandom_range(1, int'(l)) : -1;
      if (gh == ab) gh = -1;
      run_test(b, l, $urandom, 1'($urandom), ab, gh, dk);
    end
    stuck_en = 0;

    // reset in the middle of a write phase
    @(posedge clk); #1;
    base_addr = 5; length = 8; seed = 7; mode = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #2;
    chk("pre_rst_cs", chipselect, 1);
    reset_n = 0;
    #1;
    chk("mid_rst_cs", chipselect, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", address, 0);
    chk("mid_rst_wdata", writedata, 0);
    chk("mid_rst_be", byteenable, 0);
    @(posedge clk); #1;
    chk("mid_rst_cs2", chipselect, 0);
    reset_n = 1;
    run_test(10, 2, 32'h44, 0, -1, -1, dk);
    chk("post_rst_done", dk, 2 * NPASS * 2 + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
